// File: rtl/grey_pkg.sv
// grey_pkg: one-bit-step decade grey code table shared by the counter and the seven-segment decoder
package grey_pkg;
  localparam logic [4:0] pZERO  = 5'b10001;
  localparam logic [4:0] pONE   = 5'b00001;
  localparam logic [4:0] pTWO   = 5'b00011;
  localparam logic [4:0] pTHREE = 5'b00010;
  localparam logic [4:0] pFOUR  = 5'b00110;
  localparam logic [4:0] pFIVE  = 5'b00100;
  localparam logic [4:0] pSIX   = 5'b01100;
  localparam logic [4:0] pSEVEN = 5'b01000;
  localparam logic [4:0] pEIGHT = 5'b11000;
  localparam logic [4:0] pNINE  = 5'b10000;
  localparam logic [4:0] pDP    = 5'b10101;

  typedef enum logic {S_RUN, S_DP} state_e;

  function automatic logic [4:0] digit_to_grey(input logic [3:0] d);
    case (d)
      4'd1:    return pONE;
      4'd2:    return pTWO;
      4'd3:    return pTHREE;
      4'd4:    return pFOUR;
      4'd5:    return pFIVE;
      4'd6:    return pSIX;
      4'd7:    return pSEVEN;
      4'd8:    return pEIGHT;
      4'd9:    return pNINE;
      default: return pZERO;
    endcase
  endfunction

  function automatic logic grey_is_digit(input logic [4:0] g);
    for (int i = 0; i < 10; i++)
      if (digit_to_grey(4'(i)) == g) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] grey_to_digit(input logic [4:0] g);
    for (int i = 0; i < 10; i++)
      if (digit_to_grey(4'(i)) == g) return 4'(i);
    return 4'd0;
  endfunction
endpackage

// File: rtl/grey_prescaler.sv
// grey_prescaler: emits one step per P_DIV enabled clocks; P_DIV=1 makes o_step follow i_en
module grey_prescaler #(
  parameter int P_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_step
);
  localparam int W = P_DIV > 1 ? $clog2(P_DIV) : 1;
  logic [W-1:0] cnt;
  assign o_step = i_en && cnt == W'(P_DIV - 1);
  always_ff @(posedge i_clk)
    if (i_rst || i_clr || o_step) cnt <= '0;
    else if (i_en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/grey_counter.sv
// grey_counter: prescaled up/down decade counter with grey-coded output, load, carry and wrap DP code
module grey_counter
  import grey_pkg::*;
#(
  parameter int P_DIV        = 4,
  parameter bit P_DP_ON_WRAP = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic [4:0] o_grey,
  output logic [3:0] o_bcd,
  output logic       o_carry
);
  state_e state_q, state_d;
  logic step, legal, wrap, carry_d;
  logic [3:0] nxt_digit, load_digit, bcd_d;
  logic [4:0] grey_d;

  grey_prescaler #(.P_DIV(P_DIV)) u_prescaler (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_load),
    .i_en  (i_en),
    .o_step(step)
  );

  assign legal      = grey_is_digit(o_grey);
  assign wrap       = i_up ? o_bcd == 4'd9 : o_bcd == 4'd0;
  assign nxt_digit  = wrap ? (i_up ? 4'd0 : 4'd9) : (i_up ? o_bcd + 4'd1 : o_bcd - 4'd1);
  assign load_digit = i_load_val > 4'd9 ? 4'd0 : i_load_val;

  always_ff @(posedge i_clk)
    if (i_rst) state_q <= S_RUN;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (i_load) state_d = S_RUN;
    else if (step) state_d = (state_q == S_RUN && legal && wrap && P_DP_ON_WRAP) ? S_DP : S_RUN;
  end

  // A corrupted code in RUN is repaired to zero on the next step rather than counted from.
  always_comb begin
    bcd_d   = o_bcd;
    grey_d  = o_grey;
    carry_d = 1'b0;
    if (i_load) begin
      bcd_d  = load_digit;
      grey_d = digit_to_grey(load_digit);
    end else if (step && state_q == S_DP) begin
      grey_d = digit_to_grey(o_bcd);
    end else if (step && !legal) begin
      bcd_d  = 4'd0;
      grey_d = pZERO;
    end else if (step) begin
      bcd_d   = nxt_digit;
      carry_d = wrap;
      grey_d  = (wrap && P_DP_ON_WRAP) ? pDP : digit_to_grey(nxt_digit);
    end
  end

  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_grey  <= pZERO;
      o_bcd   <= 4'd0;
      o_carry <= 1'b0;
    end else begin
      o_grey  <= grey_d;
      o_bcd   <= bcd_d;
      o_carry <= carry_d;
    end
endmodule

// File: tb/tb_grey_counter.sv
// tb_grey_counter: directed checks of grey_counter with P_DIV=4 and DP on wrap
module tb_grey_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [4:0] grey, prev;
  logic [3:0] bcd;
  logic       carry;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] codes [10] = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                             5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};
  localparam logic [4:0] DP = 5'b10101;

  grey_counter #(.P_DIV(4), .P_DP_ON_WRAP(1'b1)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_up      (up),
    .i_load    (load),
    .i_load_val(load_val),
    .o_grey    (grey),
    .o_bcd     (bcd),
    .o_carry   (carry)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_grey", grey, 5'b10001);
    check("rst_bcd", bcd, 0);
    check("rst_carry", carry, 0);
    rst = 1'b0;
    en = 1'b1;
    up = 1'b1;
    for (int d = 1; d < 10; d++) begin
      prev = grey;
      tick(3);
      check($sformatf("hold_%0d", d), grey, codes[d-1]);
      tick();
      check($sformatf("up_grey_%0d", d), grey, codes[d]);
      check($sformatf("up_bcd_%0d", d), bcd, d);
      check($sformatf("onebit_%0d", d), 32'($countones(prev ^ grey)), 1);
    end
    tick(4);
    check("wrap_up_carry", carry, 1);
    check("wrap_up_dp", grey, DP);
    check("wrap_up_bcd", bcd, 0);

    do_load(4'd9);
    check("load9_grey", grey, 5'b10000);
    check("load9_carry", carry, 0);
    tick(4);
    check("t2_carry", carry, 1);
    check("t2_dp", grey, DP);
    check("t2_bcd", bcd, 0);
    tick();
    check("t2_carry_pulse", carry, 0);
    tick(2);
    check("t2_dp_held", grey, DP);
    tick();
    check("t2_dp_end_grey", grey, 5'b10001);
    check("t2_dp_end_bcd", bcd, 0);
    check("t2_dp_end_carry", carry, 0);

    up = 1'b0;
    do_load(4'd0);
    check("load0_grey", grey, 5'b10001);
    tick(4);
    check("t3_carry", carry, 1);
    check("t3_dp", grey, DP);
    check("t3_bcd", bcd, 9);
    up = 1'b1;
    tick(4);
    check("t3_dp_end_grey", grey, 5'b10000);
    check("t3_dp_end_bcd", bcd, 9);
    check("t3_dp_end_carry", carry, 0);
    up = 1'b0;
    tick(4);
    check("t3_down8_grey", grey, 5'b11000);
    check("t3_down8_bcd", bcd, 8);

    tick(2);
    en = 1'b0;
    tick(10);
    check("t4_frozen", grey, 5'b11000);
    en = 1'b1;
    tick();
    check("t4_resume_hold", grey, 5'b11000);
    tick();
    check("t4_resume_step", grey, 5'b01000);
    check("t4_resume_bcd", bcd, 7);

    tick(3);
    do_load(4'd12);
    check("t5_grey", grey, 5'b10001);
    check("t5_bcd", bcd, 0);
    check("t5_carry", carry, 0);
    tick(3);
    check("t5_presc_clr", grey, 5'b10001);
    tick();
    check("t5_wrap_carry", carry, 1);
    check("t5_wrap_dp", grey, DP);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_grey", grey, 5'b10001);
    check("t6_rst_carry", carry, 0);
    check("t6_rst_bcd", bcd, 0);

    up = 1'b1;
    do_load(4'd5);
    check("t6_load5", grey, 5'b00100);
    tick();
    force dut.o_grey = 5'b11111;
    tick();
    release dut.o_grey;
    #1;
    check("t6_corrupt", grey, 5'b11111);
    tick(2);
    check("t6_repair_grey", grey, 5'b10001);
    check("t6_repair_bcd", bcd, 0);
    check("t6_repair_carry", carry, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
